// File: rtl/fifo_pkg.sv
// Shared types and helpers for the async FIFO write-side controller.
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 4;
  localparam int DEPTH = 2 ** (FIFO_ADDR_WIDTH - 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arb_ctrl_if.sv
// Requester-side handshake bus shared by all writers of the FIFO.
interface fifo_wr_arb_ctrl_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;

  modport master (output req_valid, output req_last, output req_data, input req_ready);
  modport slave  (input req_valid, input req_last, input req_data, output req_ready);

endinterface

// File: rtl/fifo_wr_arb_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter with frame lock; grants nothing while en is low.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  input  logic               lock,
  input  logic [IW-1:0]      lock_id,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx
);

  logic hit;

  // While locked only the frame owner may win; otherwise the first valid
  // index at or after rr_ptr wins, so the descending loop keeps the nearest.
  always_comb begin
    hit       = 1'b0;
    grant_idx = '0;
    if (en) begin
      if (lock) begin
        if (req[lock_id]) begin
          hit       = 1'b1;
          grant_idx = lock_id;
        end
      end else begin
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
          if (req[(int'(rr_ptr) + k) % NUM_REQ]) begin
            hit       = 1'b1;
            grant_idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
          end
        end
      end
    end
    grant = hit ? (NUM_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/fifo_wr_arb_ctrl.sv
// Write-side controller of the async FIFO: arbitrates requesters onto the
// memory write port and maintains the binary/Gray write pointers and full flag.
module fifo_wr_arb_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int NUM_REQ    = 2,
  localparam int IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  fifo_wr_arb_ctrl_if.slave     req_if,
  input  logic [ADDR_WIDTH-1:0] wq2_rptr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [ADDR_WIDTH-2:0] waddr,
  output logic                  wclken,
  output logic [ADDR_WIDTH-1:0] wptr,
  output logic                  wfull,
  output logic [IW-1:0]         grant_id
);

  state_t                state_q, state_d;
  logic [IW-1:0]         rr_q, rr_d, rr_inc, win_idx;
  logic [NUM_REQ-1:0]    grant;
  logic                  arb_en, win_last;
  logic [ADDR_WIDTH-1:0] wbin, wbin_next, wgray_next, full_cmp;

  // Holding the arbiter off during reset makes ready/enable/data drop at once.
  assign arb_en = wrst_n & ~wfull;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IW     (IW)
  ) u_arb (
    .req      (req_if.req_valid),
    .rr_ptr   (rr_q),
    .lock     (state_q == LOCKED),
    .lock_id  (grant_id),
    .en       (arb_en),
    .grant    (grant),
    .grant_idx(win_idx)
  );

  assign req_if.req_ready = grant;
  assign wclken     = |(req_if.req_valid & grant);
  assign wdata      = wclken ? req_if.req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign waddr      = wbin[ADDR_WIDTH-2:0];
  assign win_last   = req_if.req_last[win_idx];
  assign rr_inc     = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
  assign wbin_next  = wbin + ADDR_WIDTH'(wclken);
  assign wgray_next = ADDR_WIDTH'(bin2gray(32'(wbin_next)));
  assign full_cmp   = {~wq2_rptr[ADDR_WIDTH-1:ADDR_WIDTH-2], wq2_rptr[ADDR_WIDTH-3:0]};

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // A frame ends on an accepted last beat; only then does the rotation advance.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    if (wclken) begin
      if (win_last) begin
        state_d = IDLE;
        rr_d    = rr_inc;
      end else begin
        state_d = LOCKED;
      end
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rr_q     <= '0;
      wbin     <= '0;
      wptr     <= '0;
      wfull    <= 1'b0;
      grant_id <= '0;
    end else begin
      rr_q     <= rr_d;
      wbin     <= wbin_next;
      wptr     <= wgray_next;
      wfull    <= (wgray_next == full_cmp);
      if (wclken) grant_id <= win_idx;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// Self-checking bench for fifo_wr_arb_ctrl: directed scenarios plus random
// traffic, all compared against an occupancy/ownership model of the FIFO.
module tb_fifo_wr_arb_ctrl;
  import fifo_pkg::*;

  localparam int DW = 8;
  localparam int AW = FIFO_ADDR_WIDTH;
  localparam int NR = 2;
  localparam int PTR_MOD = 2 * DEPTH;

  logic          wclk = 1'b0;
  logic          wrst_n = 1'b0;
  logic [AW-1:0] wq2_rptr;
  logic [DW-1:0] wdata;
  logic [AW-2:0] waddr;
  logic          wclken;
  logic [AW-1:0] wptr;
  logic          wfull;
  logic [0:0]    grant_id;

  int tests_run = 0;
  int tests_failed = 0;

  int m_owner = -1;
  int m_rr = 0;
  int m_wcount = 0;
  int m_gid = 0;
  int m_rbin = 0;
  bit m_full = 1'b0;

  fifo_wr_arb_ctrl_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arb_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_REQ   (NR)
  ) dut (
    .wclk    (wclk),
    .wrst_n  (wrst_n),
    .req_if  (bus),
    .wq2_rptr(wq2_rptr),
    .wdata   (wdata),
    .waddr   (waddr),
    .wclken  (wclken),
    .wptr    (wptr),
    .wfull   (wfull),
    .grant_id(grant_id)
  );

  always #5 wclk = ~wclk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int modelWinner(input logic [NR-1:0] v);
    if (m_full) return -1;
    if (m_owner >= 0) return v[m_owner] ? m_owner : -1;
    for (int k = 0; k < NR; k++) begin
      if (v[(m_rr + k) % NR]) return (m_rr + k) % NR;
    end
    return -1;
  endfunction

  // One wclk cycle: drive at the falling edge, check, then advance the model.
  task automatic applyStimulus(input logic [NR-1:0] v, input logic [NR-1:0] l, input int rb);
    int win;
    logic [NR*DW-1:0] d;
    d = (NR*DW)'($urandom);
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
    m_rbin   = rb % PTR_MOD;
    wq2_rptr = AW'(m_rbin ^ (m_rbin >> 1));
    #1;
    win = modelWinner(v);
    checkOutput("req_ready", 32'(bus.req_ready), (win >= 0) ? 32'(1 << win) : 32'd0);
    checkOutput("wclken", 32'(wclken), (win >= 0) ? 32'd1 : 32'd0);
    if (win >= 0) checkOutput("wdata", 32'(wdata), 32'(d[win*DW +: DW]));
    checkOutput("waddr", 32'(waddr), 32'(m_wcount % DEPTH));
    checkOutput("wptr", 32'(wptr), 32'(m_wcount ^ (m_wcount >> 1)));
    checkOutput("wfull", 32'(wfull), 32'(m_full));
    checkOutput("grant_id", 32'(grant_id), 32'(m_gid));
    @(posedge wclk);
    if (win >= 0) begin
      m_gid    = win;
      m_wcount = (m_wcount + 1) % PTR_MOD;
      if (l[win]) begin
        m_owner = -1;
        m_rr    = (win + 1) % NR;
      end else begin
        m_owner = win;
      end
    end
    m_full = (((m_wcount - m_rbin + PTR_MOD) % PTR_MOD) == DEPTH);
    @(negedge wclk);
  endtask

  // Asserts reset between clock edges with requesters active; everything must drop at once.
  task automatic doReset(input logic [NR-1:0] v);
    bus.req_valid = v;
    bus.req_last  = '0;
    bus.req_data  = 16'hA5C3;
    #2;
    wrst_n = 1'b0;
    #1;
    checkOutput("rst_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("rst_wclken", 32'(wclken), 32'd0);
    checkOutput("rst_wdata", 32'(wdata), 32'd0);
    checkOutput("rst_wptr", 32'(wptr), 32'd0);
    checkOutput("rst_waddr", 32'(waddr), 32'd0);
    checkOutput("rst_wfull", 32'(wfull), 32'd0);
    checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
    m_owner  = -1;
    m_rr     = 0;
    m_wcount = 0;
    m_gid    = 0;
    m_rbin   = 0;
    m_full   = 1'b0;
    wq2_rptr = '0;
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  initial begin
    int rb;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    wq2_rptr      = '0;
    @(negedge wclk);

    $display("[TB] fill to full with single beats");
    doReset(2'b11);
    for (int i = 0; i < DEPTH; i++) applyStimulus(2'b01, 2'b01, 0);
    checkOutput("t1_wptr_full", 32'(wptr), 32'b1100);
    checkOutput("t1_wfull", 32'(wfull), 32'd1);
    applyStimulus(2'b01, 2'b01, 0);

    $display("[TB] read side frees three, writes wrap");
    applyStimulus(2'b01, 2'b01, 3);
    for (int i = 0; i < 3; i++) applyStimulus(2'b01, 2'b01, 3);
    checkOutput("t5_wfull_again", 32'(wfull), 32'd1);
    applyStimulus(2'b01, 2'b01, 8);
    for (int i = 0; i < 5; i++) applyStimulus(2'b01, 2'b01, 8);
    checkOutput("t5_wptr_wrap", 32'(wptr), 32'd0);

    $display("[TB] alternating single beats");
    doReset(2'b11);
    for (int i = 0; i < 8; i++) applyStimulus(2'b11, 2'b11, m_wcount);

    $display("[TB] three-beat frame blocks other requester");
    doReset(2'b11);
    applyStimulus(2'b11, 2'b10, m_wcount);
    applyStimulus(2'b11, 2'b10, m_wcount);
    applyStimulus(2'b11, 2'b11, m_wcount);
    applyStimulus(2'b11, 2'b11, m_wcount);
    checkOutput("t3_grant_id", 32'(grant_id), 32'd1);

    $display("[TB] owner pauses mid-frame");
    doReset(2'b11);
    applyStimulus(2'b11, 2'b10, m_wcount);
    applyStimulus(2'b10, 2'b10, m_wcount);
    applyStimulus(2'b10, 2'b10, m_wcount);
    applyStimulus(2'b11, 2'b11, m_wcount);
    applyStimulus(2'b11, 2'b11, m_wcount);

    $display("[TB] reset in the middle of a frame");
    doReset(2'b11);
    applyStimulus(2'b01, 2'b00, m_wcount);
    applyStimulus(2'b01, 2'b00, m_wcount);
    doReset(2'b11);
    applyStimulus(2'b10, 2'b10, m_wcount);
    applyStimulus(2'b11, 2'b11, m_wcount);

    $display("[TB] random traffic");
    doReset(2'b00);
    for (int i = 0; i < 3000; i++) begin
      rb = m_rbin;
      if (m_rbin != m_wcount) begin
        if (((i / 400) % 2) == 1) begin
          if ($urandom_range(0, 7) == 0) rb = m_rbin + 1;
        end else begin
          if ($urandom_range(0, 3) != 0) rb = m_rbin + 1;
        end
      end
      applyStimulus(NR'($urandom), NR'($urandom), rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
